// File: rtl/elevator_scan_ctrl.sv
// SCAN-order elevator car controller: pending-request bitmap, per-floor travel timing,
// door dwell with over-weight hold, and a door-held alarm.
module elevator_scan_ctrl #(
  parameter int FLOORS        = 8,
  parameter int FLOOR_W       = $clog2(FLOORS),
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6,
  parameter int MAX_OPEN      = 20,
  parameter int HOME_FLOOR    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  input  logic               over_weight,
  output logic [FLOOR_W-1:0] current_floor,
  output logic               direction,
  output logic               moving,
  output logic               door_open,
  output logic               arrive,
  output logic [FLOORS-1:0]  pending,
  output logic               weight_alert,
  output logic               timer_alert
);
  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam int OW = $clog2(MAX_OPEN + 1);
  localparam logic [TW-1:0]     TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0]     DOOR_LOAD   = DW'(DOOR_CYCLES - 1);
  localparam logic [OW-1:0]     OPEN_FIRST  = OW'(1);
  localparam logic [FLOORS-1:0] BIT0        = FLOORS'(1);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t             state, state_nx;
  logic [FLOOR_W-1:0] floor_q, floor_nx, next_floor;
  logic               dir_q, dir_nx;
  logic [FLOORS-1:0]  pend_q, pend_nx, req_mask, clr_mask, cur_mask, next_mask;
  logic [TW-1:0]      travel_q, travel_nx;
  logic [DW-1:0]      door_q, door_nx;
  logic [OW-1:0]      open_q, open_nx;
  logic               arrive_q, arrive_nx;
  logic               req_ok, any_up, any_down;

  // True when vec holds a request strictly above (up=1) or below (up=0) floor 'from'.
  function automatic logic beyond(input logic [FLOORS-1:0] vec,
                                  input logic [FLOOR_W-1:0] from,
                                  input logic up);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (vec[i] && (up ? (i > int'(from)) : (i < int'(from)))) hit = 1'b1;
    end
    return hit;
  endfunction

  assign req_ok     = req_valid && (32'(req_floor) < FLOORS);
  assign req_mask   = req_ok ? (BIT0 << req_floor) : '0;
  assign cur_mask   = BIT0 << floor_q;
  assign next_floor = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
  assign next_mask  = BIT0 << next_floor;
  assign any_up     = beyond(pend_q, floor_q, 1'b1);
  assign any_down   = beyond(pend_q, floor_q, 1'b0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      floor_q  <= FLOOR_W'(HOME_FLOOR);
      dir_q    <= 1'b1;
      pend_q   <= '0;
      travel_q <= '0;
      door_q   <= '0;
      open_q   <= '0;
      arrive_q <= 1'b0;
    end else begin
      state    <= state_nx;
      floor_q  <= floor_nx;
      dir_q    <= dir_nx;
      pend_q   <= pend_nx;
      travel_q <= travel_nx;
      door_q   <= door_nx;
      open_q   <= open_nx;
      arrive_q <= arrive_nx;
    end
  end

  // A request for the floor being served is absorbed: clr_mask overrides the new set bit.
  always_comb begin
    state_nx  = state;
    floor_nx  = floor_q;
    dir_nx    = dir_q;
    travel_nx = travel_q;
    door_nx   = door_q;
    open_nx   = '0;
    arrive_nx = 1'b0;
    clr_mask  = '0;
    case (state)
      IDLE: begin
        if (|(pend_q & cur_mask)) begin
          state_nx = DOOR;
          clr_mask = cur_mask;
          door_nx  = DOOR_LOAD;
          open_nx  = OPEN_FIRST;
        end else if (any_up && (dir_q || !any_down)) begin
          state_nx  = MOVE;
          dir_nx    = 1'b1;
          travel_nx = TRAVEL_LOAD;
        end else if (any_down) begin
          state_nx  = MOVE;
          dir_nx    = 1'b0;
          travel_nx = TRAVEL_LOAD;
        end
      end
      MOVE: begin
        if (travel_q == '0) begin
          floor_nx  = next_floor;
          arrive_nx = 1'b1;
          if (|((pend_q | req_mask) & next_mask)) begin
            state_nx = DOOR;
            clr_mask = next_mask;
            door_nx  = DOOR_LOAD;
            open_nx  = OPEN_FIRST;
          end else if (beyond(pend_q, next_floor, dir_q)) begin
            travel_nx = TRAVEL_LOAD;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          travel_nx = travel_q - TW'(1);
        end
      end
      DOOR: begin
        open_nx = (32'(open_q) < MAX_OPEN) ? open_q + OW'(1) : open_q;
        if (req_ok && (req_floor == floor_q)) begin
          door_nx  = DOOR_LOAD;
          clr_mask = cur_mask;
        end else if (!over_weight) begin
          if (door_q == '0) begin
            state_nx = IDLE;
            open_nx  = '0;
          end else begin
            door_nx = door_q - DW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pend_nx       = (pend_q | req_mask) & ~clr_mask;
  assign current_floor = floor_q;
  assign direction     = dir_q;
  assign moving        = (state == MOVE);
  assign door_open     = (state == DOOR);
  assign arrive        = arrive_q;
  assign pending       = pend_q;
  assign weight_alert  = (state == DOOR) && over_weight;
  assign timer_alert   = (32'(open_q) >= MAX_OPEN);

endmodule
